// File: rtl/inst_fetch_sequencer_if.sv
// Bus between the instruction fetch sequencer, the instruction ROM and the execution datapath.
// The master side is the sequencer; the slave side is the ROM/datapath environment.
interface inst_fetch_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              InstEnable;
    logic [ADDR_W-1:0] InstAddress;
    logic [DATA_W-1:0] InstData;
    logic              OpValid;
    logic [7:0]        OpCode;
    logic [7:0]        Src1;
    logic [7:0]        Src2;
    logic [7:0]        Dest;
    logic              OpDone;

    modport master (
        output InstEnable, InstAddress, OpValid, OpCode, Src1, Src2, Dest,
        input  InstData, OpDone
    );

    modport slave (
        input  InstEnable, InstAddress, OpValid, OpCode, Src1, Src2, Dest,
        output InstData, OpDone
    );
endinterface

// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: reads the instruction ROM from address 0, decodes and issues one
// operation at a time over valid/done. Optional macro ILLEGAL_OP_TRAP_EN traps illegal opcodes.
//
// state  | meaning
// IDLE   | waiting for Start after reset
// FETCH  | InstEnable high, ROM registers word at PC
// LATCH  | instruction register captures InstData
// DECODE | classify opcode: issue / skip / stop / illegal
// ISSUE  | OpValid held until OpDone
// NEXT   | advance PC or halt at last address
// HALT   | program finished, Start restarts from address 0
module inst_fetch_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Start,
    inst_fetch_sequencer_if.master bus,
    output logic                  Busy,
    output logic                  Halted,
    output logic                  Error
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_STOP = 8'hFF;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              inst_enable;
    logic [DATA_W-1:0] ir;
    logic              op_valid;
    logic [7:0]        op_code;
    logic [7:0]        src1;
    logic [7:0]        src2;
    logic [7:0]        dest;

    logic [7:0]        ir_op;
    logic              op_issue;
    logic              op_stop;
    logic              op_nop;
    logic              pc_last;

    assign ir_op   = ir[31:24];
    assign pc_last = (pc == {ADDR_W{1'b1}});

    always_comb begin
        op_issue = 1'b0;
        op_stop  = 1'b0;
        op_nop   = 1'b0;
        case (ir_op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05: op_issue = 1'b1;
            OP_STOP:                            op_stop  = 1'b1;
            OP_NOP:                             op_nop   = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic error_flag;
`endif

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            inst_enable <= 1'b0;
            ir          <= '0;
            op_valid    <= 1'b0;
            op_code     <= 8'h00;
            src1        <= 8'h00;
            src2        <= 8'h00;
            dest        <= 8'h00;
`ifdef ILLEGAL_OP_TRAP_EN
            error_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        pc          <= '0;
                        inst_enable <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    inst_enable <= 1'b0;
                    state       <= ST_LATCH;
                end
                ST_LATCH: begin
                    ir    <= bus.InstData;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (op_issue) begin
                        op_code  <= ir[31:24];
                        src1     <= ir[23:16];
                        src2     <= ir[15:8];
                        dest     <= ir[7:0];
                        op_valid <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (op_stop) begin
                        state <= ST_HALT;
                    end else if (op_nop) begin
                        state <= ST_NEXT;
                    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                        error_flag <= 1'b1;
                        state      <= ST_HALT;
`else
                        state <= ST_NEXT;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (bus.OpDone) begin
                        op_valid <= 1'b0;
                        state    <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // The PC never wraps: finishing the last word ends the program.
                    if (pc_last) begin
                        state <= ST_HALT;
                    end else begin
                        pc          <= pc + 1'b1;
                        inst_enable <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (Start) begin
                        pc          <= '0;
                        inst_enable <= 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
                        error_flag  <= 1'b0;
`endif
                        state       <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign Error = error_flag;
`else
    assign Error = 1'b0;
`endif

    assign Busy   = (state != ST_IDLE) && (state != ST_HALT);
    assign Halted = (state == ST_HALT);

    assign bus.InstEnable  = inst_enable;
    assign bus.InstAddress = pc;
    assign bus.OpValid     = op_valid;
    assign bus.OpCode      = op_code;
    assign bus.Src1        = src1;
    assign bus.Src2        = src2;
    assign bus.Dest        = dest;

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Scoreboard bench for inst_fetch_sequencer: a registered ROM model, a configurable OpDone responder
// and a monitor that pops expected operations whenever OpValid rises.
module tb_inst_fetch_sequencer;

    logic Clock = 1'b0;
    logic nReset;
    logic Start;
    logic Busy;
    logic Halted;
    logic Error;

    always #5 Clock = ~Clock;

    inst_fetch_sequencer_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    inst_fetch_sequencer #(.ADDR_W(4), .DATA_W(32)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Start  (Start),
        .bus    (bus),
        .Busy   (Busy),
        .Halted (Halted),
        .Error  (Error)
    );

    logic [31:0] rom [16];
    logic [31:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int en_pulses = 0;
    int max_addr = 0;
    int last_addr = 0;
    int hold_cycles = 0;
    int done_delay = 0;
    bit done_tied = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Registered ROM: word appears on InstData after the edge that samples InstEnable.
    always @(posedge Clock) begin
        if (bus.InstEnable) bus.InstData <= rom[bus.InstAddress];
    end

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        bus.OpDone = 1'b0;
        forever begin
            @(negedge Clock);
            if (done_tied) begin
                bus.OpDone = 1'b1;
            end else if (bus.OpValid) begin
                if (wait_cnt >= done_delay) bus.OpDone = 1'b1;
                wait_cnt++;
            end else begin
                bus.OpDone = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic        prev_valid;
        logic [31:0] cur;
        logic [31:0] held;
        logic [3:0]  held_addr;
        logic [31:0] want;
        prev_valid = 1'b0;
        held = '0;
        held_addr = '0;
        forever begin
            @(negedge Clock);
            cur = {bus.OpCode, bus.Src1, bus.Src2, bus.Dest};
            if (bus.InstEnable) begin
                en_pulses++;
                last_addr = int'(bus.InstAddress);
                if (last_addr > max_addr) max_addr = last_addr;
            end
            if (bus.OpValid && !prev_valid) begin
                issue_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", cur, 32'hxxxxxxxx);
                end else begin
                    want = exp_q.pop_front();
                    chk("issue_fields", cur, want);
                end
                held = cur;
                held_addr = bus.InstAddress;
            end else if (bus.OpValid) begin
                hold_cycles++;
                chk("hold_fields", cur, held);
                chk("hold_pc", {28'd0, bus.InstAddress}, {28'd0, held_addr});
                chk("hold_no_fetch", {31'd0, bus.InstEnable}, 32'd0);
            end
            prev_valid = bus.OpValid;
        end
    end

    task automatic do_reset;
        @(negedge Clock);
        nReset = 1'b0;
        Start = 1'b0;
        @(posedge Clock);
        #1;
        chk("reset_ctrl", {23'd0, bus.InstEnable, bus.InstAddress, bus.OpValid, Busy, Halted, Error}, 32'd0);
        chk("reset_fields", {bus.OpCode, bus.Src1, bus.Src2, bus.Dest}, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        en_pulses = 0;
        max_addr = 0;
        issue_cnt = 0;
        hold_cycles = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    endtask

    task automatic pulse_start;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        int n;
        n = 0;
        while (!Halted && n < max_cycles) begin
            @(negedge Clock);
            n++;
        end
        chk("halt_reached", {31'd0, Halted}, 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int edges;
        nReset = 1'b0;
        Start = 1'b0;

        // Single add, OpDone tied high; measure Start-to-OpValid latency.
        do_reset();
        rom[0] = 32'h01011121;
        rom[1] = 32'hFF000000;
        done_tied = 1'b1;
        exp_q.push_back(32'h01011121);
        @(negedge Clock);
        Start = 1'b1;
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            Start = 1'b0;
            edges++;
            if (bus.OpValid) break;
        end
        chk("start_latency", edges, 4);
        chk("first_fetch_pulses", en_pulses, 1);
        chk("first_fetch_addr", last_addr, 0);
        wait_halt(50);
        chk("t1_issues", issue_cnt, 1);
        chk("t1_queue_empty", exp_q.size(), 0);
        done_tied = 1'b0;

        // Six-word program, OpDone delayed 3 cycles per op.
        do_reset();
        rom[0] = 32'h01011121;
        rom[1] = 32'h02210131;
        rom[2] = 32'h05210241;
        rom[3] = 32'h04417202;
        rom[4] = 32'h03024151;
        rom[5] = 32'hFF000000;
        done_delay = 3;
        exp_q.push_back(32'h01011121);
        exp_q.push_back(32'h02210131);
        exp_q.push_back(32'h05210241);
        exp_q.push_back(32'h04417202);
        exp_q.push_back(32'h03024151);
        pulse_start();
        wait_halt(200);
        chk("t2_issues", issue_cnt, 5);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_halt_addr", {28'd0, bus.InstAddress}, 32'd5);
        chk("t2_max_addr", max_addr, 5);
        chk("t2_not_busy", {31'd0, Busy}, 32'd0);

        // OpDone withheld for 20 cycles: fields, PC and InstEnable frozen.
        do_reset();
        rom[0] = 32'h03010203;
        rom[1] = 32'hFF000000;
        done_delay = 20;
        exp_q.push_back(32'h03010203);
        pulse_start();
        wait_halt(200);
        chk("t3_issues", issue_cnt, 1);
        chk("t3_hold_cycles", hold_cycles, 20);
        chk("t3_fetches", en_pulses, 2);
        chk("t3_fields_after", {bus.OpCode, bus.Src1, bus.Src2, bus.Dest}, 32'h03010203);

        // Fifteen NOPs then a sub at the last address; halts without wrap.
        do_reset();
        rom[15] = 32'h02000000;
        done_delay = 0;
        exp_q.push_back(32'h02000000);
        pulse_start();
        wait_halt(300);
        chk("t4_issues", issue_cnt, 1);
        chk("t4_fetches", en_pulses, 16);
        chk("t4_halt_addr", {28'd0, bus.InstAddress}, 32'd15);
        repeat (10) @(negedge Clock);
        chk("t4_no_wrap_fetch", en_pulses, 16);
        chk("t4_no_wrap_addr", {28'd0, bus.InstAddress}, 32'd15);
        chk("t4_still_halted", {31'd0, Halted}, 32'd1);

        // Illegal opcode 0x07 at address 1.
        do_reset();
        rom[0] = 32'h01010203;
        rom[1] = 32'h07AABBCC;
        rom[2] = 32'h04050607;
        rom[3] = 32'hFF000000;
        exp_q.push_back(32'h01010203);
`ifdef ILLEGAL_OP_TRAP_EN
        pulse_start();
        wait_halt(100);
        chk("t5_error_set", {31'd0, Error}, 32'd1);
        chk("t5_trap_issues", issue_cnt, 1);
        chk("t5_trap_addr", {28'd0, bus.InstAddress}, 32'd1);
        exp_q.push_back(32'h01010203);
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        chk("t5_start_clears", {30'd0, Error, Halted}, 32'd0);
        wait_halt(100);
        chk("t5_error_again", {31'd0, Error}, 32'd1);
        chk("t5_issues_total", issue_cnt, 2);
`else
        exp_q.push_back(32'h04050607);
        pulse_start();
        wait_halt(100);
        chk("t5_skip_issues", issue_cnt, 2);
        chk("t5_halt_addr", {28'd0, bus.InstAddress}, 32'd3);
        chk("t5_fetches", en_pulses, 4);
        chk("t5_no_error", {31'd0, Error}, 32'd0);
`endif
        chk("t5_queue_empty", exp_q.size(), 0);

        // Start held while Busy, then reset in the middle of ISSUE.
        do_reset();
        rom[0] = 32'h01112233;
        rom[1] = 32'hFF000000;
        done_delay = 20;
        exp_q.push_back(32'h01112233);
        @(negedge Clock);
        Start = 1'b1;
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            edges++;
            if (bus.OpValid) break;
        end
        chk("t6_latency_start_held", edges, 4);
        chk("t6_single_fetch", en_pulses, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk("t6_busy_pc", {28'd0, bus.InstAddress}, 32'd0);
            chk("t6_busy_valid", {31'd0, bus.OpValid}, 32'd1);
        end
        @(negedge Clock);
        Start = 1'b0;
        nReset = 1'b0;
        @(posedge Clock);
        #1;
        chk("t6_reset_ctrl", {23'd0, bus.InstEnable, bus.InstAddress, bus.OpValid, Busy, Halted, Error}, 32'd0);
        chk("t6_reset_fields", {bus.OpCode, bus.Src1, bus.Src2, bus.Dest}, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        chk("t6_issues", issue_cnt, 1);
        chk("t6_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_sequencer.md
Name: inst_fetch_sequencer

Overview:
- Reader side of the 16x32 instruction ROM: drives its Enable/Address, captures the returned 32-bit word, decodes opcode/src1/src2/dest, and issues one matrix operation at a time to the execution datapath.
- Datapath handshake is valid/done.
- Runs from address 0 until a STOP opcode or the end of ROM, then halts.
- Sits between the instruction ROM and the ALU/matrix-memory control in the top level.

Parameters:
- ADDR_W, 4: instruction address width; ROM depth is 2**ADDR_W.
- DATA_W, 32: instruction width; fields are [31:24] opcode, [23:16] src1, [15:8] src2, [7:0] dest.

Ports:
- Clock, input, 1: single clock, all logic on posedge.
- nReset, input, 1: synchronous, active-low reset.
- Start, input, 1: begin execution at address 0; sampled only in IDLE or HALT.
- InstEnable, output, 1: ROM enable, registered.
- InstAddress, output, ADDR_W: ROM address (PC), registered.
- InstData, input, DATA_W: ROM DataOut.
- OpValid, output, 1: operation issued; held until OpDone.
- OpCode, output, 8: decoded opcode.
- Src1, output, 8: decoded src1 field.
- Src2, output, 8: decoded src2 field.
- Dest, output, 8: decoded dest field.
- OpDone, input, 1: datapath completion; sampled only in ISSUE.
- Busy, output, 1: high in every state except IDLE and HALT.
- Halted, output, 1: high in HALT.
- Error, output, 1: illegal-opcode trap flag (see Optional Feature).

Behaviour:
- Reset (nReset=0 at posedge): state=IDLE, PC=0. All outputs are 0: InstEnable, InstAddress, OpValid, OpCode, Src1, Src2, Dest, Busy, Halted, Error. Reset mid-ISSUE drops OpValid at that same edge.
- Opcodes:
  - 0x01 add, 0x02 sub, 0x03 multiply, 0x04 scale, 0x05 transpose: issued.
  - 0xFF: stop.
  - 0x00: NOP, skipped with no issue.
  - All others: illegal.
- State transitions:
  - IDLE: Start=1 -> FETCH with PC=0.
  - FETCH (1 cycle): InstEnable=1, InstAddress=PC. The ROM registers the word at the edge leaving FETCH. -> LATCH.
  - LATCH (1 cycle): InstEnable=0. The instruction register captures InstData at the edge leaving LATCH. -> DECODE.
  - DECODE (1 cycle), by opcode:
    - Valid op: load OpCode, Src1, Src2, Dest and set OpValid=1 at the exit edge -> ISSUE.
    - NOP: -> NEXT.
    - 0xFF: -> HALT.
    - Illegal: per Optional Feature.
  - ISSUE: OpValid and the fields stay stable. OpDone=1 at an edge -> clear OpValid at that edge -> NEXT. OpDone is legal in the first ISSUE cycle.
  - NEXT (1 cycle):
    - PC == 2**ADDR_W-1: -> HALT (implicit end of program; Error unchanged).
    - Otherwise: PC+1 -> FETCH.
  - HALT: Halted=1. Start=1 -> clear Halted and Error, PC=0 -> FETCH.
- Latency: Start to OpValid = 4 edges (IDLE->FETCH->LATCH->DECODE->ISSUE). OpDone to next OpValid = 5 edges minimum.
- Start is ignored while Busy. OpDone is ignored outside ISSUE.
- PC never wraps. Execution past the last address always halts.
- OpCode, Src1, Src2 and Dest hold their last issued values after OpValid drops and in HALT.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an illegal opcode in DECODE sets Error=1 and goes to HALT with no issue. Error stays set until reset or Start.
- Undefined: an illegal opcode is treated as a NOP (-> NEXT). Error is tied 0.

Test Plan:
- Reset, then Start, with ROM[0]=0x01011121 and OpDone tied 1:
  - OpValid rises 4 edges after Start with OpCode=0x01, Src1=0x01, Src2=0x11, Dest=0x21.
  - InstEnable pulses once with InstAddress=0.
- Program add, sub, transpose, scale, multiply, stop (0x01011121, 0x02210131, 0x05210241, 0x04417202, 0x03024151, 0xFF000000), with OpDone delayed 3 cycles per op:
  - Exactly 5 issues in order.
  - Halted=1 after address 5; InstAddress never exceeds 5.
- OpDone held low for 20 cycles in ISSUE:
  - OpValid and the fields stay stable throughout.
  - No InstEnable pulse.
  - PC advances only after OpDone=1.
- ROM all 0x00 except ROM[15]=0x02000000:
  - 15 NOPs skipped with no OpValid.
  - One sub issued from address 15, then HALT with no wrap.
- Illegal opcode 0x07 at address 1 after a valid op at 0:
  - With ILLEGAL_OP_TRAP_EN: Error=1 and Halted=1 with no issue; Start clears both.
  - Without the macro: skipped, and execution continues at address 2.
- nReset=0 mid-ISSUE and Start pulsed while Busy:
  - Reset clears all outputs at the next edge.
  - Start while Busy causes no PC change.
